// File: rtl/serv_rf_ram_resp.sv
// serv_rf_ram_resp: parity-protected register-file RAM for SERV.
// Zero-fills after reset; 1-cycle reads with write-first bypass.
module serv_rf_ram_resp #(
  parameter int width    = 8,
  parameter int csr_regs = 4,
  parameter int raw      = $clog2(32+csr_regs),
  parameter int aw       = 5+raw-$clog2(width),
  parameter int depth    = (32+csr_regs)*32/width
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [aw-1:0]    i_waddr,
  input  logic [width-1:0] i_wdata,
  input  logic             i_wen,
  input  logic [aw-1:0]    i_raddr,
  input  logic             i_ren,
  output logic [width-1:0] o_rdata,
  output logic             o_init_done,
  output logic             o_perr,
  output logic             o_perr_sticky,
  input  logic             i_perr_clr,
  input  logic             i_inj_perr
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [aw-1:0] last = aw'(depth-1);
  localparam logic [aw:0]   lim  = (aw+1)'(depth);

  state_t          state;
  logic [aw-1:0]   cnt;
  logic [width:0]  mem [depth];
  logic [width:0]  word;
  logic            we;
  logic [aw-1:0]   wa;
  logic [width:0]  wd;
  logic            hit;
  logic            rd_ok;
  logic            perr_nxt;

  // Fill writes own the port in INIT; client writes only in RUN.
  always_comb begin
    we = 1'b0;
    wa = cnt;
    wd = '0;
    if (state == INIT) begin
      we = !i_rst;
    end else if (i_wen && ({1'b0, i_waddr} < lim)) begin
      we = 1'b1;
      wa = i_waddr;
      wd = {^i_wdata ^ i_inj_perr, i_wdata};
    end
  end

  always_ff @(posedge i_clk) begin
    if (we) mem[wa] <= wd;
  end

  assign word  = mem[i_raddr];
  assign hit   = i_wen && (i_raddr == i_waddr);
  assign rd_ok = {1'b0, i_raddr} < lim;

  assign perr_nxt = (state == RUN) && i_ren && !hit && rd_ok &&
                    (word[width] != ^word[width-1:0]);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= INIT;
      cnt         <= '0;
      o_init_done <= 1'b0;
    end else if (state == INIT) begin
      if (cnt == last) begin
        state       <= RUN;
        o_init_done <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rdata       <= '0;
      o_perr        <= 1'b0;
      o_perr_sticky <= 1'b0;
    end else begin
      o_perr <= perr_nxt;
      if (perr_nxt)
        o_perr_sticky <= 1'b1;
      else if (i_perr_clr)
        o_perr_sticky <= 1'b0;
      if (i_ren) begin
        if (state == INIT)
          o_rdata <= '0;
        else if (hit)
          o_rdata <= i_wdata;
        else
          o_rdata <= word[width-1:0];
      end
    end
  end

endmodule

// File: tb/tb_serv_rf_ram_resp.sv
// tb_serv_rf_ram_resp: random + directed bench for serv_rf_ram_resp
// against an array-based reference model.
module tb_serv_rf_ram_resp;

  localparam int DEPTH = 144;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] waddr, raddr, wdata;
  logic       wen, ren, clr, inj;
  logic [7:0] rdata;
  logic       done, perr, sticky;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] m_mem [DEPTH];
  bit         m_bad [DEPTH];
  logic [7:0] m_rdata;
  bit         m_perr, m_sticky, m_done;
  int         fill_cnt;

  always #5 clk = ~clk;

  serv_rf_ram_resp dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_waddr(waddr),
    .i_wdata(wdata),
    .i_wen(wen),
    .i_raddr(raddr),
    .i_ren(ren),
    .o_rdata(rdata),
    .o_init_done(done),
    .o_perr(perr),
    .o_perr_sticky(sticky),
    .i_perr_clr(clr),
    .i_inj_perr(inj)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_rdata"}, 32'(rdata), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_perr"}, 32'(perr), 0);
    chk({tag, "_sticky"}, 32'(sticky), 0);
  endtask

  task automatic idle();
    wen = 0; ren = 0; clr = 0; inj = 0;
    waddr = 0; raddr = 0; wdata = 0;
  endtask

  task automatic rand_in();
    wen   = 1'($urandom_range(0, 1));
    ren   = 1'($urandom_range(0, 1));
    waddr = 8'($urandom_range(0, DEPTH-1));
    wdata = 8'($urandom);
    raddr = ($urandom % 4 == 0) ? waddr
          : 8'($urandom_range(0, DEPTH-1));
    inj   = ($urandom % 8 == 0);
    clr   = ($urandom % 4 == 0);
  endtask

  // One clock: advance the model with the applied inputs, then compare.
  task automatic step();
    bit pe;
    @(posedge clk);
    pe = 0;
    if (rst) begin
      m_rdata = 0; m_sticky = 0; m_done = 0; fill_cnt = 0;
    end else begin
      if (!m_done) begin
        if (ren) m_rdata = 0;
        fill_cnt++;
        if (fill_cnt == DEPTH) begin
          m_done = 1;
          for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = 0;
            m_bad[i] = 0;
          end
        end
      end else begin
        if (ren) begin
          if (wen && raddr == waddr) begin
            m_rdata = wdata;
          end else begin
            m_rdata = m_mem[raddr];
            pe = m_bad[raddr];
          end
        end
        if (wen) begin
          m_mem[waddr] = wdata;
          m_bad[waddr] = inj;
        end
      end
      if (pe) m_sticky = 1;
      else if (clr) m_sticky = 0;
    end
    m_perr = pe;
    #1;
    chk("rdata", 32'(rdata), 32'(m_rdata));
    chk("perr", 32'(perr), 32'(m_perr));
    chk("sticky", 32'(sticky), 32'(m_sticky));
    chk("done", 32'(done), 32'(m_done));
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      rand_in();
      step();
      if (i == DEPTH-2) chk("done_lo", 32'(done), 0);
    end
  endtask

  initial begin
    int fa [4] = '{0, 77, 143, 3};
    idle();
    rst = 1;
    step();
    chk_rst("por");
    step();
    rst = 0;

    for (int i = 0; i < DEPTH; i++) begin
      rand_in();
      if (i == 10) begin
        wen = 1; waddr = 8'h03; wdata = 8'hFF;
      end
      step();
      if (i == DEPTH-2) chk("done_lo", 32'(done), 0);
    end
    chk("done_hi", 32'(done), 1);

    foreach (fa[k]) begin
      idle(); ren = 1; raddr = 8'(fa[k]);
      step();
      chk("fill_rd", 32'(rdata), 0);
      chk("fill_perr", 32'(perr), 0);
    end

    idle(); wen = 1; waddr = 8'h10; wdata = 8'hA5;
    step();
    idle(); ren = 1; raddr = 8'h10;
    step();
    chk("wr_rd", 32'(rdata), 32'hA5);
    idle();
    step();
    chk("hold", 32'(rdata), 32'hA5);

    idle(); wen = 1; waddr = 8'h22; wdata = 8'h11;
    step();
    wdata = 8'h3C; ren = 1; raddr = 8'h22;
    step();
    chk("bypass", 32'(rdata), 32'h3C);

    idle(); wen = 1; waddr = 8'h05; wdata = 8'h01; inj = 1;
    step();
    idle(); ren = 1; raddr = 8'h05;
    step();
    chk("inj_rd", 32'(rdata), 32'h01);
    chk("inj_perr", 32'(perr), 1);
    chk("inj_sticky", 32'(sticky), 1);
    idle();
    step();
    chk("pulse_end", 32'(perr), 0);
    idle(); clr = 1;
    step();
    chk("clr", 32'(sticky), 0);
    idle(); clr = 1; ren = 1; raddr = 8'h05;
    step();
    chk("clr_vs_err", 32'(sticky), 1);

    repeat (3000) begin
      rand_in();
      step();
    end

    idle(); wen = 1; waddr = 8'h40; wdata = 8'h5A; inj = 1;
    step();
    idle(); ren = 1; raddr = 8'h40;
    step();
    rst = 1;
    #1;
    chk_rst("run_rst");
    idle();
    repeat (2) step();
    rst = 0;
    fill(50);
    rst = 1;
    #1;
    chk_rst("fill_rst");
    repeat (2) step();
    rst = 0;
    fill(DEPTH);
    chk("refill_done", 32'(done), 1);
    idle(); ren = 1; raddr = 8'h40;
    step();
    chk("refill_rd", 32'(rdata), 0);
    chk("refill_perr", 32'(perr), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
